// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, MSB-first deserializer
// with even parity, stop-bit and break detection, plus registered RTS flow control.
module uart_rx #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 FIFO_Full,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Rdy,
  output logic [2:0]           Rx_Error,
  output logic                 RTS,
  output logic                 Rx_Busy
);

  localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic                 line_hi, par_err, frm_err;
  logic                 tick, done, brk;

  always_comb begin
    state_n = state;
    tick    = 1'b0;
    done    = 1'b0;
    brk     = 1'b0;
    case (state)
      IDLE: if (!rx_s) state_n = START;
      START: begin
        tick = (cnt == HALF_M1);
        if (tick) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        tick = (cnt == FULL_M1);
        if (tick && bit_cnt == LAST_DATA) state_n = (PARITY_BIT != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tick = (cnt == FULL_M1);
        if (tick) state_n = STOP;
      end
      STOP: begin
        tick = (cnt == FULL_M1);
        if (tick && bit_cnt == LAST_STOP) begin
          done    = 1'b1;
          // break: nothing after the start bit was ever seen high, this sample included
          brk     = !line_hi && !rx_s;
          state_n = brk ? BRK_WAIT : IDLE;
        end
      end
      BRK_WAIT: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      Rx_Busy  <= 1'b0;
      RTS      <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      line_hi  <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      Data_Rdy <= 1'b0;
      Data_Out <= '0;
      Rx_Error <= 3'b000;
    end else begin
      rx_m    <= Rx;
      rx_s    <= rx_m;
      RTS     <= !FIFO_Full;
      state   <= state_n;
      Rx_Busy <= (state_n != IDLE);
      cnt     <= (state == IDLE || tick) ? '0 : cnt + 1'b1;

      // bit_cnt restarts whenever a sample moves the FSM to a new phase
      if (state == IDLE || (tick && state_n != state)) bit_cnt <= '0;
      else if (tick)                                  bit_cnt <= bit_cnt + 1'b1;

      if (state == IDLE) begin
        line_hi <= 1'b0;
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end else if (tick) begin
        case (state)
          DATA: begin
            sh      <= (sh << 1) | DATA_BITS'(rx_s);
            line_hi <= line_hi | rx_s;
          end
          PARITY: begin
            par_err <= (rx_s != ^sh);
            line_hi <= line_hi | rx_s;
          end
          STOP: begin
            if (!rx_s) frm_err <= 1'b1;
            line_hi <= line_hi | rx_s;
          end
          default: ;
        endcase
      end

      Data_Rdy <= done;
      if (done) begin
        Data_Out <= brk ? '0 : sh;
        Rx_Error <= brk ? 3'b001 : {frm_err | ~rx_s, par_err, 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit, 8 data bits, even parity, 2 stops.
module tb_uart_rx;

  logic       Clk = 1'b0;
  logic       Rst, Rx, FIFO_Full;
  logic [7:0] Data_Out;
  logic       Data_Rdy, RTS, Rx_Busy;
  logic [2:0] Rx_Error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nstrobe = 0;
  logic [10:0] exp_q[$];
  int rdy_cyc_q[$];

  uart_rx #(.SYSCLK_RATE(160), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .FIFO_Full(FIFO_Full),
    .Data_Out(Data_Out), .Data_Rdy(Data_Rdy), .Rx_Error(Rx_Error),
    .RTS(RTS), .Rx_Busy(Rx_Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && Data_Rdy) begin
      logic [10:0] e;
      nstrobe++;
      rdy_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_rdy", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("data_out", 32'(Data_Out), 32'(e[10:3]));
        chk("rx_error", 32'(Rx_Error), 32'(e[2:0]));
      end
    end
  end

  task automatic hold_bit(input logic b);
    Rx = b;
    repeat (16) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic [1:0] stops,
                            input logic [2:0] exp_err);
    exp_q.push_back({d, exp_err});
    hold_bit(1'b0);
    for (int i = 7; i >= 0; i--) hold_bit(d[i]);
    hold_bit(par);
    hold_bit(stops[1]);
    hold_bit(stops[0]);
    Rx = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc, lat, s0;
    Rst = 1'b1; Rx = 1'b1; FIFO_Full = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_data_out", 32'(Data_Out), 0);
    chk("rst_data_rdy", 32'(Data_Rdy), 0);
    chk("rst_rx_error", 32'(Rx_Error), 0);
    chk("rst_rts", 32'(RTS), 0);
    chk("rst_busy", 32'(Rx_Busy), 0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rts_after_rst", 32'(RTS), 1);
    repeat (5) @(negedge Clk);

    // valid frame with latency check, then a back-to-back frame
    rdy_cyc_q.delete();
    start_cyc = cyc;
    send_frame(8'hA5, 1'b0, 2'b11, 3'b000);
    send_frame(8'h3C, 1'b0, 2'b11, 3'b000);
    drain();
    lat = (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - start_cyc : 0;
    chk("latency_in_window", 32'(lat >= 183 && lat <= 187), 1);
    chk("b2b_strobes", 32'(rdy_cyc_q.size()), 2);

    // parity and frame errors
    send_frame(8'hAA, 1'b1, 2'b11, 3'b010);
    drain();
    send_frame(8'hAA, 1'b0, 2'b00, 3'b100);
    drain();
    send_frame(8'hAA, 1'b1, 2'b01, 3'b110);
    drain();

    // break: 20 bit times low
    s0 = nstrobe;
    exp_q.push_back({8'h00, 3'b001});
    Rx = 1'b0;
    repeat (320) @(negedge Clk);
    chk("brk_busy_low_line", 32'(Rx_Busy), 1);
    chk("brk_strobes_low", nstrobe - s0, 1);
    Rx = 1'b1;
    repeat (100) @(negedge Clk);
    chk("brk_one_strobe", nstrobe - s0, 1);
    chk("brk_busy_released", 32'(Rx_Busy), 0);
    chk("brk_queue_empty", exp_q.size(), 0);
    send_frame(8'h01, 1'b1, 2'b11, 3'b000);
    drain();

    // false start
    s0 = nstrobe;
    Rx = 1'b0;
    repeat (4) @(negedge Clk);
    Rx = 1'b1;
    repeat (40) @(negedge Clk);
    chk("false_start_no_rdy", nstrobe - s0, 0);
    chk("false_start_idle", 32'(Rx_Busy), 0);

    // reset in mid-DATA
    Rx = 1'b0;
    repeat (16) @(negedge Clk);
    Rx = 1'b1;
    repeat (40) @(negedge Clk);
    chk("mid_busy", 32'(Rx_Busy), 1);
    Rst = 1'b1;
    @(negedge Clk);
    chk("mid_rst_busy", 32'(Rx_Busy), 0);
    Rst = 1'b0;
    repeat (300) @(negedge Clk);
    chk("mid_rst_no_rdy", nstrobe - s0, 0);
    send_frame(8'hC3, 1'b0, 2'b11, 3'b000);
    drain();

    // flow control
    FIFO_Full = 1'b1;
    @(negedge Clk);
    chk("rts_low", 32'(RTS), 0);
    send_frame(8'h55, 1'b0, 2'b11, 3'b000);
    drain();
    chk("rts_still_low", 32'(RTS), 0);
    FIFO_Full = 1'b0;
    @(negedge Clk);
    chk("rts_high", 32'(RTS), 1);

    repeat (20) @(negedge Clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
